uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Upstream stage of the UART transmitter. Buffers bytes from the system side in a
//  synchronous FIFO and launches them one at a time into the UART TX: one-cycle
//  DATA_VALID pulse, then waits out the TX BUSY flag before launching the next byte.
//  Holds the byte stable on TX_P_DATA for the whole frame.
// PARAMETERS
//  DATA_WIDTH  8  width of one UART payload word
//  DEPTH       8  FIFO entries; power of two, >= 2
//  ADDR_WIDTH  3  log2(DEPTH); must match DEPTH
// PORTS
//  CLK            in   1             system clock, rising edge
//  RST            in   1             asynchronous, active-low reset
//  WR_DATA        in   DATA_WIDTH    byte to enqueue
//  WR_EN          in   1             enqueue strobe; ignored while FULL
//  FULL           out  1             FIFO holds DEPTH entries
//  EMPTY          out  1             FIFO holds 0 entries
//  COUNT          out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  TX_P_DATA      out  DATA_WIDTH    parallel byte to UART TX serializer
//  TX_DATA_VALID  out  1             one-cycle launch pulse to UART TX FSM
//  TX_BUSY        in   1             registered busy flag from UART TX FSM
// BEHAVIOUR
//  - Reset: FULL=0, EMPTY=1, COUNT=0, TX_P_DATA=0, TX_DATA_VALID=0, pointers=0, state IDLE.
//    Reset mid-frame drops all queued bytes and the in-flight launch state immediately.
//  - FIFO: write accepted iff WR_EN && !FULL, decided on the FULL value at the edge,
//    independent of a pop in that cycle. Pointers ADDR_WIDTH+1 bits, wrap modulo 2*DEPTH;
//    FULL = MSBs differ and low bits equal; EMPTY = pointers equal. COUNT = wr_ptr-rd_ptr.
//    Simultaneous accepted write + pop: COUNT unchanged. Write while FULL: dropped, no state change.
//  - Launch FSM (all outputs registered):
//    IDLE       : if !EMPTY -> pop head into TX_P_DATA, go LAUNCH.
//    LAUNCH     : TX_DATA_VALID=1 for exactly this cycle; go WAIT_BUSY.
//    WAIT_BUSY  : wait for TX_BUSY=1 (TX BUSY is registered, rises >=2 cycles after pulse);
//                 on TX_BUSY=1 go WAIT_DONE.
//    WAIT_DONE  : wait for TX_BUSY=0; then go IDLE (next launch no earlier than next cycle).
//  - Latency: byte written at edge k into an empty FIFO with FSM in IDLE -> popped at edge k+1,
//    TX_DATA_VALID high in the cycle after edge k+2... i.e. pulse visible 2 edges after write.
//  - TX_P_DATA changes only on a pop; stable from LAUNCH through WAIT_DONE.
//  - Never more than one TX_DATA_VALID pulse per TX_BUSY high period.
//  - Unused state encodings recover to IDLE, TX_DATA_VALID=0.
// CONFIGURATION
//  UART_TX_FEEDER_OVF_EN defined: adds ports OVF_CLR (in,1) and OVERFLOW (out,1). OVERFLOW
//   sets on the edge where WR_EN && FULL, sticks until OVF_CLR=1 (set wins if both same
//   cycle); reset value 0.
//  Not defined: ports absent, writes while FULL silently dropped, no other change.
// TESTING
//  1 Reset: RST=0 mid-frame with COUNT=3 -> EMPTY=1, COUNT=0, TX_DATA_VALID=0 same cycle.
//  2 Single byte: write 0xA5 to empty FIFO, TX model idle -> one pulse 2 edges later,
//    TX_P_DATA=0xA5 held until TX_BUSY falls; EMPTY=1 after pop.
//  3 Burst: write 0x01..0x08 back-to-back, TX model busy 11 cycles per frame -> 8 pulses in
//    order 0x01..0x08, each only after previous TX_BUSY fall; FULL never blocks (pop first).
//  4 Overflow: hold TX_BUSY=1, write 9 bytes 0x10..0x18 -> FULL after 8th, 0x18 dropped,
//    COUNT=8; with UART_TX_FEEDER_OVF_EN OVERFLOW=1 until OVF_CLR pulse.
//  5 Simultaneous: COUNT=4, write 0x55 same cycle as pop -> COUNT stays 4, 0x55 emitted 4th later.
//  6 Pointer wrap: stream 20 bytes through DEPTH=8 -> all 20 emitted in order, no loss/duplicate.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_if
//   Bundles the system-side write port and the UART TX launch port of
//   uart_tx_feeder into one interface.
//
//   Build option: UART_TX_FEEDER_OVF_EN adds OVF_CLR / OVERFLOW.
//
//   Signals:
//     WR_DATA, WR_EN         system -> feeder   enqueue a byte
//     FULL, EMPTY, COUNT     feeder -> system   FIFO occupancy
//     TX_P_DATA              feeder -> UART TX  byte held for the whole frame
//     TX_DATA_VALID          feeder -> UART TX  one-cycle launch pulse
//     TX_BUSY                UART TX -> feeder  registered frame-in-progress flag
//     OVF_CLR, OVERFLOW      sticky write-while-full flag (optional)
//
//   Handshake: a write is taken on a rising edge where WR_EN=1 and FULL=0;
//   with FULL=1 the write is dropped. Toward the UART, TX_DATA_VALID is a
//   single-cycle pulse. No further pulse is issued until TX_BUSY has been
//   seen high and then low again.
//
//   Modports: slave = the feeder itself, master = the system/UART side.
// ---------------------------------------------------------------------------
interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_EN;
  logic                  FULL;
  logic                  EMPTY;
  logic [ADDR_WIDTH:0]   COUNT;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_DATA_VALID;
  logic                  TX_BUSY;
`ifdef UART_TX_FEEDER_OVF_EN
  logic                  OVF_CLR;
  logic                  OVERFLOW;
`endif

  modport slave (
    input  WR_DATA, WR_EN, TX_BUSY,
`ifdef UART_TX_FEEDER_OVF_EN
    input  OVF_CLR,
    output OVERFLOW,
`endif
    output FULL, EMPTY, COUNT, TX_P_DATA, TX_DATA_VALID
  );

  modport master (
    output WR_DATA, WR_EN, TX_BUSY,
`ifdef UART_TX_FEEDER_OVF_EN
    output OVF_CLR,
    input  OVERFLOW,
`endif
    input  FULL, EMPTY, COUNT, TX_P_DATA, TX_DATA_VALID
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//   Buffers system bytes in a synchronous FIFO and launches them one at a
//   time into the UART TX. For each byte it pops the FIFO head into
//   TX_P_DATA and gives a one-cycle TX_DATA_VALID pulse. It then waits for
//   TX_BUSY to rise and fall before it pops the next byte.
//
//   Build option: UART_TX_FEEDER_OVF_EN adds a sticky OVERFLOW flag that is
//   set by a write while FULL and cleared by OVF_CLR. If both occur in the
//   same cycle, the set wins.
//
//   Ports:
//     CLK        system clock, rising edge
//     RST        asynchronous, active-low reset
//     bus        uart_tx_feeder_if.slave (write port + UART TX port)
//     dbg_state  current launch FSM state (IDLE=0, LAUNCH=1, WAIT_BUSY=2,
//                WAIT_DONE=3)
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_feeder_if.slave       bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
  logic                  tx_valid_q, tx_valid_d;

  logic full;
  logic empty;
  logic wr_accept;
  logic pop;

  // The pointers carry one extra wrap bit. Equal pointers mean empty. When
  // only the wrap bit differs, the FIFO is full.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  // Acceptance depends only on FULL as it stands at the edge. A pop in the
  // same cycle does not open a slot for this write.
  assign wr_accept = bus.WR_EN && !full;

  always_comb begin
    state_d     = state_q;
    tx_p_data_d = tx_p_data_q;
    tx_valid_d  = 1'b0;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          tx_p_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // The pulse is registered, so it is high for exactly one cycle,
        // two edges after a write into an idle, empty feeder.
        tx_valid_d = 1'b1;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.TX_BUSY) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.TX_BUSY) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d = wr_accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop       ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      tx_p_data_q <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      tx_p_data_q <= tx_p_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  // Storage needs no reset. Emptiness is defined entirely by the pointers.
  always_ff @(posedge CLK) begin
    if (wr_accept) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.WR_DATA;
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.OVF_CLR)          ovf_d = 1'b0;
    if (bus.WR_EN && full)    ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign bus.OVERFLOW = ovf_q;
`endif

  assign bus.FULL          = full;
  assign bus.EMPTY         = empty;
  assign bus.COUNT         = wr_ptr_q - rd_ptr_q;
  assign bus.TX_P_DATA     = tx_p_data_q;
  assign bus.TX_DATA_VALID = tx_valid_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
//   Directed bench for uart_tx_feeder. A small UART TX model raises TX_BUSY
//   two edges after it sees a pulse and holds it for busy_len cycles. While
//   force_busy is set, the model holds TX_BUSY high.
//   Bytes launched by the feeder are collected in got_q.
//   They are compared against the hand-built exp_q.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] dbg_state;

  uart_tx_feeder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // ---------------- UART TX model ----------------
  int busy_len   = 5;
  bit force_busy = 1'b0;
  int start_cnt  = 0;
  int busy_cnt   = 0;
  int violations = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.TX_BUSY <= 1'b0;
      start_cnt   <= 0;
      busy_cnt    <= 0;
    end else if (force_busy) begin
      bus.TX_BUSY <= 1'b1;
      start_cnt   <= 0;
      busy_cnt    <= 0;
    end else if (bus.TX_DATA_VALID) begin
      // A second pulse before the previous frame has finished is a protocol error.
      if (bus.TX_BUSY || start_cnt != 0) violations <= violations + 1;
      start_cnt <= 1;
    end else if (start_cnt != 0) begin
      bus.TX_BUSY <= 1'b1;
      busy_cnt    <= busy_len - 1;
      start_cnt   <= 0;
    end else if (bus.TX_BUSY) begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      else              bus.TX_BUSY <= 1'b0;
    end
  end

  // Launch monitor, sampled away from the active edge.
  always @(negedge CLK) begin
    if (RST && bus.TX_DATA_VALID) got_q.push_back(bus.TX_P_DATA);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.WR_DATA = d;
    bus.WR_EN   = 1'b1;
    @(negedge CLK);
    bus.WR_EN   = 1'b0;
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n;
    n = 0;
    while (!(bus.EMPTY && dbg_state == 2'd0 && !bus.TX_BUSY && start_cnt == 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: still busy after %0d cycles, required drained", name, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    checks++; if (bus.EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.EMPTY); end
    checks++; if (bus.FULL !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.FULL); end
    checks++; if (bus.COUNT !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.COUNT); end
    checks++; if (bus.TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.TX_DATA_VALID); end
    checks++; if (bus.TX_P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata got=%h exp=00", bus.TX_P_DATA); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
`ifdef UART_TX_FEEDER_OVF_EN
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.OVERFLOW); end
`endif
    RST = 1'b1;
    repeat (2) tick();
    checks++; if (bus.EMPTY !== 1'b1) begin errors++; $display("FAIL reset_release_empty got=%b exp=1", bus.EMPTY); end
  endtask

  task automatic test_single();
    int n;
    bit held_bad;
    exp_q.delete(); got_q.delete();
    busy_len = 5;
    exp_q.push_back(8'hA5);
    write_byte(8'hA5);                // edge k
    checks++; if (bus.COUNT !== 4'd1) begin errors++; $display("FAIL single_count_k got=%0d exp=1", bus.COUNT); end
    checks++; if (bus.TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL single_valid_k got=%b exp=0", bus.TX_DATA_VALID); end
    tick();                           // edge k+1: pop
    checks++; if (bus.EMPTY !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop got=%b exp=1", bus.EMPTY); end
    checks++; if (bus.TX_P_DATA !== 8'hA5) begin errors++; $display("FAIL single_pdata got=%h exp=a5", bus.TX_P_DATA); end
    checks++; if (bus.TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL single_valid_k1 got=%b exp=0", bus.TX_DATA_VALID); end
    tick();                           // edge k+2: pulse
    checks++; if (bus.TX_DATA_VALID !== 1'b1) begin errors++; $display("FAIL single_valid_k2 got=%b exp=1", bus.TX_DATA_VALID); end
    tick();                           // edge k+3
    checks++; if (bus.TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL single_valid_k3 got=%b exp=0", bus.TX_DATA_VALID); end
    held_bad = 1'b0;
    n = 0;
    while (dbg_state != 2'd0 && n < 50) begin
      if (bus.TX_P_DATA !== 8'hA5) held_bad = 1'b1;
      tick();
      n++;
    end
    checks++; if (held_bad || n >= 50) begin errors++; $display("FAIL single_hold held_bad=%b cycles=%0d exp held a5 until idle", held_bad, n); end
    wait_drained(100, "single");
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_stream got_n=%0d exp_n=1 exp=a5", got_q.size()); end
  endtask

  task automatic test_burst();
    bit full_seen;
    exp_q.delete(); got_q.delete();
    busy_len = 11;
    full_seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      write_byte(8'(i));
      if (bus.FULL) full_seen = 1'b1;
    end
    checks++; if (full_seen) begin errors++; $display("FAIL burst_full got=1 exp=0"); end
    wait_drained(1000, "burst");
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL burst_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL burst_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (violations !== 0) begin errors++; $display("FAIL burst_one_pulse_per_frame violations=%0d exp=0", violations); end
  endtask

  task automatic test_overflow();
    exp_q.delete(); got_q.delete();
    force_busy = 1'b1;
    exp_q.push_back(8'h0F);
    write_byte(8'h0F);                // in flight; FSM parks in WAIT_DONE
    repeat (4) tick();
    checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL ovf_parked_state got=%0d exp=3", dbg_state); end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      write_byte(8'h10 + 8'(i));
    end
    checks++; if (bus.FULL !== 1'b1) begin errors++; $display("FAIL ovf_full8 got=%b exp=1", bus.FULL); end
    checks++; if (bus.COUNT !== 4'd8) begin errors++; $display("FAIL ovf_count8 got=%0d exp=8", bus.COUNT); end
`ifdef UART_TX_FEEDER_OVF_EN
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_flag_before got=%b exp=0", bus.OVERFLOW); end
`endif
    write_byte(8'h18);                // dropped
    checks++; if (bus.COUNT !== 4'd8) begin errors++; $display("FAIL ovf_count_after_drop got=%0d exp=8", bus.COUNT); end
    checks++; if (bus.FULL !== 1'b1) begin errors++; $display("FAIL ovf_full_after_drop got=%b exp=1", bus.FULL); end
`ifdef UART_TX_FEEDER_OVF_EN
    checks++; if (bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag_set got=%b exp=1", bus.OVERFLOW); end
    repeat (2) tick();
    checks++; if (bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag_sticky got=%b exp=1", bus.OVERFLOW); end
    bus.OVF_CLR = 1'b1; tick(); bus.OVF_CLR = 1'b0;
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_flag_clr got=%b exp=0", bus.OVERFLOW); end
    bus.OVF_CLR = 1'b1; write_byte(8'h19); bus.OVF_CLR = 1'b0;
    checks++; if (bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", bus.OVERFLOW); end
    bus.OVF_CLR = 1'b1; tick(); bus.OVF_CLR = 1'b0;
    checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_flag_clr2 got=%b exp=0", bus.OVERFLOW); end
`endif
    busy_len = 3;
    force_busy = 1'b0;
    wait_drained(1000, "overflow");
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_q.delete(); got_q.delete();
    busy_len = 4;
    force_busy = 1'b1;
    exp_q.push_back(8'h20);
    write_byte(8'h20);
    repeat (3) tick();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      write_byte(8'h20 + 8'(i));
    end
    checks++; if (bus.COUNT !== 4'd4) begin errors++; $display("FAIL simul_count_pre got=%0d exp=4", bus.COUNT); end
    // Busy falls at e1, FSM returns to IDLE at e2, pop happens at e3.
    force_busy = 1'b0;
    tick();
    tick();
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL simul_idle got=%0d exp=0", dbg_state); end
    exp_q.push_back(8'h55);
    write_byte(8'h55);                // write and pop on the same edge
    checks++; if (bus.COUNT !== 4'd4) begin errors++; $display("FAIL simul_count got=%0d exp=4", bus.COUNT); end
    checks++; if (bus.TX_P_DATA !== 8'h21) begin errors++; $display("FAIL simul_pdata got=%h exp=21", bus.TX_P_DATA); end
    wait_drained(1000, "simul");
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL simul_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL simul_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    exp_q.delete(); got_q.delete();
    busy_len = 2;
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (bus.FULL && n < 200) begin tick(); n++; end
      exp_q.push_back(8'h30 + 8'(i));
      write_byte(8'h30 + 8'(i));
    end
    wait_drained(2000, "wrap");
    checks++; if (got_q.size() != 20) begin errors++; $display("FAIL wrap_len got=%0d exp=20", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    force_busy = 1'b1;
    write_byte(8'h3F);
    repeat (3) tick();
    write_byte(8'h40);
    write_byte(8'h41);
    write_byte(8'h42);
    checks++; if (bus.COUNT !== 4'd3) begin errors++; $display("FAIL rstmid_count_pre got=%0d exp=3", bus.COUNT); end
    got_q.delete();
    RST = 1'b0;
    #1;
    checks++; if (bus.EMPTY !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", bus.EMPTY); end
    checks++; if (bus.COUNT !== 4'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", bus.COUNT); end
    checks++; if (bus.TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", bus.TX_DATA_VALID); end
    checks++; if (bus.TX_P_DATA !== 8'h00) begin errors++; $display("FAIL rstmid_pdata got=%h exp=00", bus.TX_P_DATA); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
    force_busy = 1'b0;
    tick();
    RST = 1'b1;
    repeat (6) tick();
    checks++; if (got_q.size() != 0 || bus.EMPTY !== 1'b1) begin errors++; $display("FAIL rstmid_no_launch got_n=%0d empty=%b exp 0/1", got_q.size(), bus.EMPTY); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    RST         = 1'b0;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = 8'h00;
`ifdef UART_TX_FEEDER_OVF_EN
    bus.OVF_CLR = 1'b0;
`endif
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid_frame();
    checks++; if (violations !== 0) begin errors++; $display("FAIL total_violations got=%0d exp=0", violations); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
